// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID pipeline register, field decode, branch/jump
// resolution with redirect to fetch, and load-use hazard detection.
module id_stage #(
  parameter logic [31:0] NOP_WORD  = 32'h00000000,
  parameter logic [31:0] HALT_WORD = 32'hffffffff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstructionF,
  input  logic [31:0] PC4,
  input  logic        StopF,
  input  logic [31:0] RD1,
  input  logic [31:0] RD2,
  input  logic        ExMemRead,
  input  logic [4:0]  ExRt,
  output logic [1:0]  PCSource,
  output logic [31:0] PC_B,
  output logic [31:0] aD,
  output logic [31:0] PC_J,
  output logic        isLWHazard,
  output logic [31:0] InstructionD,
  output logic [31:0] PC4D,
  output logic [4:0]  Rs,
  output logic [4:0]  Rt,
  output logic [4:0]  Rd,
  output logic [31:0] ImmD,
  output logic        BubbleD,
  output logic        StopD
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] FN_JR    = 6'b001000;

  function automatic logic signed [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  logic [31:0]        instr_p1;
  logic [31:0]        pc4_p1;
  logic               stop_p1;
  logic [5:0]         op_p1;
  logic [5:0]         funct_p1;
  logic signed [31:0] imm_p1;
  logic               is_rtype, is_beq, is_bne, is_jump, is_jr;
  logic               rs_used, rt_used, br_taken;
  logic [1:0]         pc_src;
  logic               hazard;

  // ---- stage boundary: IF -> ID register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_p1 <= NOP_WORD;
      pc4_p1   <= 32'd0;
      stop_p1  <= 1'b0;
    end else begin
      if (StopF || InstructionF == HALT_WORD)
        stop_p1 <= 1'b1;
      if (hazard) begin
        instr_p1 <= instr_p1;
        pc4_p1   <= pc4_p1;
      end else if (pc_src != 2'b00) begin
        instr_p1 <= NOP_WORD;
        pc4_p1   <= 32'd0;
      end else begin
        instr_p1 <= InstructionF;
        pc4_p1   <= PC4;
      end
    end
  end

  // ---- ID combinational decode ----
  assign op_p1    = instr_p1[31:26];
  assign funct_p1 = instr_p1[5:0];
  assign imm_p1   = sext16(instr_p1[15:0]);

  assign is_rtype = (op_p1 == OP_RTYPE);
  assign is_beq   = (op_p1 == OP_BEQ);
  assign is_bne   = (op_p1 == OP_BNE);
  assign is_jump  = (op_p1 == OP_J) || (op_p1 == OP_JAL);
  assign is_jr    = is_rtype && (funct_p1 == FN_JR);

  // Every format except j/jal reads Rs; Rt is a source only for R-type and branches.
  assign rs_used  = !is_jump;
  assign rt_used  = is_rtype || is_beq || is_bne;
  assign hazard   = ExMemRead && (ExRt != 5'd0) &&
                    ((rs_used && ExRt == instr_p1[25:21]) ||
                     (rt_used && ExRt == instr_p1[20:16]));

  assign br_taken = (is_beq && RD1 == RD2) || (is_bne && RD1 != RD2);

  always_comb begin
    pc_src = 2'b00;
    if (!hazard && !stop_p1) begin
      if (br_taken)     pc_src = 2'b01;
      else if (is_jr)   pc_src = 2'b10;
      else if (is_jump) pc_src = 2'b11;
    end
  end

  assign PCSource     = pc_src;
  assign PC_B         = pc4_p1 + imm_p1;
  assign aD           = RD1;
  assign PC_J         = {pc4_p1[31:26], instr_p1[25:0]};
  assign isLWHazard   = hazard;
  assign BubbleD      = hazard;
  assign InstructionD = instr_p1;
  assign PC4D         = pc4_p1;
  assign Rs           = instr_p1[25:21];
  assign Rt           = instr_p1[20:16];
  assign Rd           = instr_p1[15:11];
  assign ImmD         = imm_p1;
  assign StopD        = stop_p1;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with hand-computed expected values.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] InstructionF, PC4, RD1, RD2;
  logic        StopF, ExMemRead;
  logic [4:0]  ExRt;
  logic [1:0]  PCSource;
  logic [31:0] PC_B, aD, PC_J, InstructionD, PC4D, ImmD;
  logic        isLWHazard, BubbleD, StopD;
  logic [4:0]  Rs, Rt, Rd;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  id_stage dut (
    .clk(clk), .reset(reset), .InstructionF(InstructionF), .PC4(PC4),
    .StopF(StopF), .RD1(RD1), .RD2(RD2), .ExMemRead(ExMemRead), .ExRt(ExRt),
    .PCSource(PCSource), .PC_B(PC_B), .aD(aD), .PC_J(PC_J),
    .isLWHazard(isLWHazard), .InstructionD(InstructionD), .PC4D(PC4D),
    .Rs(Rs), .Rt(Rt), .Rd(Rd), .ImmD(ImmD), .BubbleD(BubbleD), .StopD(StopD)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; InstructionF = 32'h0; PC4 = 32'h0; StopF = 1'b0;
    RD1 = 32'h0; RD2 = 32'h0; ExMemRead = 1'b0; ExRt = 5'd0;
    #12;
    chk("rst_instr", InstructionD, 32'h0);
    chk("rst_pc4d", PC4D, 32'h0);
    chk("rst_stop", {31'd0, StopD}, 32'd0);
    chk("rst_pcsrc", {30'd0, PCSource}, 32'd0);
    chk("rst_haz", {31'd0, isLWHazard}, 32'd0);
    chk("rst_bubble", {31'd0, BubbleD}, 32'd0);
    chk("rst_imm", ImmD, 32'h0);

    // beq $1,$2,-2
    reset = 1'b0;
    InstructionF = 32'h1022FFFE; PC4 = 32'h10; RD1 = 32'd5; RD2 = 32'd5;
    tick();
    chk("beq_instr", InstructionD, 32'h1022FFFE);
    chk("beq_rs", {27'd0, Rs}, 32'd1);
    chk("beq_rt", {27'd0, Rt}, 32'd2);
    chk("beq_imm", ImmD, 32'hFFFFFFFE);
    chk("beq_pcb", PC_B, 32'h0000000E);
    chk("beq_taken", {30'd0, PCSource}, 32'd1);
    RD2 = 32'd6; #1;
    chk("beq_not_taken", {30'd0, PCSource}, 32'd0);
    RD2 = 32'd5; InstructionF = 32'h8C010000; PC4 = 32'h11; #1;
    tick();
    chk("beq_flush_instr", InstructionD, 32'h0);
    chk("beq_flush_pc4d", PC4D, 32'h0);

    // jr $31
    InstructionF = 32'h03E00008; PC4 = 32'h20; RD1 = 32'h40;
    tick();
    chk("jr_pcsrc", {30'd0, PCSource}, 32'd2);
    chk("jr_aD", aD, 32'h40);
    InstructionF = 32'h8C010000;
    tick();
    chk("jr_flush", InstructionD, 32'h0);

    // j 0x123
    InstructionF = 32'h08000123; PC4 = 32'h04000005;
    tick();
    chk("j_pcsrc", {30'd0, PCSource}, 32'd3);
    chk("j_pcj", PC_J, 32'h04000123);
    InstructionF = 32'h00652020; PC4 = 32'h30;
    tick();
    chk("j_flush", InstructionD, 32'h0);
    tick();
    chk("add_instr", InstructionD, 32'h00652020);
    chk("add_rd", {27'd0, Rd}, 32'd4);

    // load-use on Rs of add $4,$3,$5
    InstructionF = 32'h8C020004; PC4 = 32'h31; ExMemRead = 1'b1; ExRt = 5'd3; #1;
    chk("lw_haz_rs", {31'd0, isLWHazard}, 32'd1);
    chk("lw_bubble", {31'd0, BubbleD}, 32'd1);
    tick();
    chk("lw_hold_instr", InstructionD, 32'h00652020);
    chk("lw_hold_pc4d", PC4D, 32'h30);
    ExRt = 5'd0; #1;
    chk("lw_r0_nostall", {31'd0, isLWHazard}, 32'd0);
    ExRt = 5'd5; #1;
    chk("lw_haz_rt", {31'd0, isLWHazard}, 32'd1);
    ExMemRead = 1'b0; #1;
    chk("lw_clear", {31'd0, isLWHazard}, 32'd0);
    tick();
    chk("lw_resume", InstructionD, 32'h8C020004);

    // hazard beats a taken branch
    InstructionF = 32'h1022FFFE; PC4 = 32'h40; RD1 = 32'd5; RD2 = 32'd5;
    tick();
    ExMemRead = 1'b1; ExRt = 5'd1; #1;
    chk("hzbr_haz", {31'd0, isLWHazard}, 32'd1);
    chk("hzbr_pcsrc", {30'd0, PCSource}, 32'd0);
    tick();
    chk("hzbr_hold", InstructionD, 32'h1022FFFE);
    ExMemRead = 1'b0; #1;
    chk("hzbr_taken", {30'd0, PCSource}, 32'd1);
    chk("hzbr_pcb", PC_B, 32'h0000003E);

    // halt word arrives while a redirect is pending
    InstructionF = 32'hFFFFFFFF; PC4 = 32'h41;
    tick();
    chk("halt_stop", {31'd0, StopD}, 32'd1);
    chk("halt_flush", InstructionD, 32'h0);
    InstructionF = 32'h1000FFFF; PC4 = 32'h50; RD1 = 32'd7; RD2 = 32'd7;
    tick();
    chk("halt_instr", InstructionD, 32'h1000FFFF);
    chk("halt_pcsrc", {30'd0, PCSource}, 32'd0);
    chk("halt_sticky", {31'd0, StopD}, 32'd1);

    // asynchronous reset mid-cycle
    #2 reset = 1'b1; #1;
    chk("arst_instr", InstructionD, 32'h0);
    chk("arst_pcsrc", {30'd0, PCSource}, 32'd0);
    chk("arst_haz", {31'd0, isLWHazard}, 32'd0);
    chk("arst_stop", {31'd0, StopD}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
